serial_adder32: RTL and testbench

Bit-serial WIDTH-bit adder for the 32-bit ALU datapath. It is the sequential stage directly downstream of the one-bit half adder: two one-bit half adders and an OR form a full adder, and a registered carry feeds that full adder one bit per clock, LSB first. The block trades 32 cycles of latency for a single full-adder slice. It reports sum, carry-out and signed overflow through a start/busy/done handshake.

---
 rtl/serial_adder32.sv | 127 ++++++++++++
 tb/tb_serial_adder32.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder32.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, LSB first, start/busy/done handshake.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             cin;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign cin   = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign cin        = 1'b0;
`endif

    // Full adder built from two half adders and an OR.
    logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;
    assign ha1_s = a_q[0] ^ b_q[0];
    assign ha1_c = a_q[0] & b_q[0];
    assign ha2_s = ha1_s ^ carry_q;
    assign ha2_c = ha1_s & carry_q;
    assign fa_c  = ha1_c | ha2_c;

    // New sum bit enters from the MSB side; on the last bit this is the full result.
    logic [WIDTH-1:0] sr_ext;
    assign sr_ext = {ha2_s, sum_sr_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                sum_sr_d = sr_ext[WIDTH-1:1];
                carry_d  = fa_c;
                if (cnt_q == LAST) begin
                    sum_d   = sr_ext;
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder32.sv
// Directed self-checking bench for serial_adder32 (WIDTH=32 and an exhaustive WIDTH=2 instance).
module tb_serial_adder32;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        sub = 1'b0;
    logic        busy, done, carry_out, overflow;
    logic [31:0] sum;

    logic        start2 = 1'b0;
    logic [1:0]  a2 = '0, b2 = '0;
    logic        busy2, done2, cout2, ovf2;
    logic [1:0]  sum2;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    serial_adder32 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    serial_adder32 #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .sub(1'b0),
        .busy(busy2), .done(done2), .sum(sum2), .carry_out(cout2), .overflow(ovf2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts edges after the accepting edge until done; 0 means it never came.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv, output int n);
        a = av; b = bv; sub = sv; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
    endtask

    initial begin
        int seen;
        int sa, sb, ss, ref_sum;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_cout", {31'b0, carry_out}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);

        run_op(32'h3, 32'h5, 1'b0, lat);
        check("lat_3p5", lat, 32'd32);
        check("sum_3p5", sum, 32'h8);
        check("cout_3p5", {31'b0, carry_out}, 32'd0);
        check("ovf_3p5", {31'b0, overflow}, 32'd0);
        tick();
        check("done_pulse_once", {31'b0, done}, 32'd0);

        run_op(32'hFFFFFFFF, 32'h1, 1'b0, lat);
        check("sum_wrap", sum, 32'h0);
        check("cout_wrap", {31'b0, carry_out}, 32'd1);
        check("ovf_wrap", {31'b0, overflow}, 32'd0);

        run_op(32'h7FFFFFFF, 32'h1, 1'b0, lat);
        check("sum_ovf", sum, 32'h80000000);
        check("cout_ovf", {31'b0, carry_out}, 32'd0);
        check("ovf_ovf", {31'b0, overflow}, 32'd1);

        // Reset in the middle of a run discards it.
        a = 32'h12345678; b = 32'h11111111; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("busy_mid_run", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_sum", sum, 32'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        check("midrst_no_done", seen, 32'd0);
        run_op(32'h12345678, 32'h11111111, 1'b0, lat);
        check("lat_after_rst", lat, 32'd32);
        check("sum_after_rst", sum, 32'h23456789);

        // Start and operand changes during RUN are ignored.
        a = 32'h10; b = 32'h20; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        a = 32'hFFFF0000; b = 32'h0000FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        check("lat_ignore", lat, 32'd26);
        check("sum_ignore", sum, 32'h30);
        tick();
        check("ignore_idle", {31'b0, busy}, 32'd0);

        // Back-to-back: start held through DONE.
        a = 32'h1; b = 32'h2; start = 1'b1;
        tick();
        wait_done(lat);
        check("b2b_lat1", lat, 32'd32);
        check("b2b_sum1", sum, 32'h3);
        a = 32'h100; b = 32'h200;
        tick();
        start = 1'b0;
        check("b2b_no_consec_done", {31'b0, done}, 32'd0);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done(lat);
        check("b2b_gap", lat + 1, 32'd33);
        check("b2b_sum2", sum, 32'h300);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        run_op(32'h5, 32'h3, 1'b1, lat);
        check("sub_5m3", sum, 32'h2);
        check("sub_5m3_cout", {31'b0, carry_out}, 32'd1);
        run_op(32'h3, 32'h5, 1'b1, lat);
        check("sub_3m5", sum, 32'hFFFFFFFE);
        check("sub_3m5_cout", {31'b0, carry_out}, 32'd0);
        run_op(32'h80000000, 32'h1, 1'b1, lat);
        check("sub_min_sum", sum, 32'h7FFFFFFF);
        check("sub_min_ovf", {31'b0, overflow}, 32'd1);
`else
        run_op(32'h5, 32'h3, 1'b1, lat);
        check("nosub_5p3", sum, 32'h8);
`endif
        sub = 1'b0;
        tick();

        // Exhaustive WIDTH=2 instance against reference arithmetic.
        for (int i = 0; i < 16; i++) begin
            a2 = 2'(i >> 2); b2 = 2'(i & 3); start2 = 1'b1;
            tick();
            start2 = 1'b0;
            seen = 0;
            for (int j = 1; j <= 10; j++) begin
                tick();
                if (done2) begin
                    seen = j;
                    break;
                end
            end
            ref_sum = int'(a2) + int'(b2);
            sa = (a2 >= 2) ? int'(a2) - 4 : int'(a2);
            sb = (b2 >= 2) ? int'(b2) - 4 : int'(b2);
            ss = sa + sb;
            check($sformatf("w2_lat_%0d", i), seen, 32'd2);
            check($sformatf("w2_sum_%0d", i), {30'b0, sum2}, 32'(ref_sum % 4));
            check($sformatf("w2_cout_%0d", i), {31'b0, cout2}, 32'(ref_sum / 4));
            check($sformatf("w2_ovf_%0d", i), {31'b0, ovf2}, (ss > 1 || ss < -2) ? 32'd1 : 32'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
